pipelined_adder: RTL and testbench

//  Parametrised, pipelined ripple-carry add/subtract unit. It is the clocked successor to the fixed 6-bit full adder.
//  The WIDTH-bit carry chain is split into STAGES equal segments, with one register stage per segment.
//  A valid/ready handshake on both sides gives full throughput (one operation per cycle) and backpressure.

---
 rtl/pipelined_adder_pkg.sv | 13 +
 rtl/adder_segment.sv | 27 ++
 rtl/pipelined_adder.sv | 136 +++++++++++++
 tb/tb_pipelined_adder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared configuration for the pipelined add/subtract unit: default sizing and
// the WIDTH/STAGES legality rule.
package pipelined_adder_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_STAGES = 4;

  // Carry chain must split into equal, non-empty segments.
  function automatic bit cfg_legal(input int unsigned width, input int unsigned stages);
    return (stages != 0) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple-carry segment built from full-adder cells.
module adder_segment #(
  parameter int unsigned SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  logic [SEG:0] c;

  // sum = a^b^c, carry = majority(a,b,c), rippled LSB to MSB.
  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < int'(SEG); i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign co = c[SEG];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry add/subtract unit: one SEG-bit carry segment per
// register stage, valid/ready on both sides, full throughput.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SEG = WIDTH / STAGES;
  localparam int unsigned MSB = WIDTH - 1;

  if (!cfg_legal(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic [WIDTH-1:0] bx;
  logic             c0;
  logic             stall;

  // Stage registers; operand copies keep the not-yet-added upper bits and sign bits.
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  bx_q  [STAGES];
  logic [WIDTH-1:0]  s_q   [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] ovf_q;

  // Per-stage inputs (from the port for stage 0, else from the previous stage).
  logic [WIDTH-1:0]  src_a  [STAGES];
  logic [WIDTH-1:0]  src_bx [STAGES];
  logic [WIDTH-1:0]  src_s  [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;

  logic [SEG-1:0]    seg_s  [STAGES];
  logic [STAGES-1:0] seg_c;
  logic [WIDTH-1:0]  nxt_s  [STAGES];
  logic [STAGES-1:0] nxt_ovf;

  // Subtraction is a + ~b + ~cin on the same carry chain.
  assign bx = sub ? ~b : b;
  assign c0 = sub ? ~cin : cin;

  assign stall    = v_q[STAGES-1] && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    src_c = '0;
    src_v = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      src_a[k]  = '0;
      src_bx[k] = '0;
      src_s[k]  = '0;
      if (k == 0) begin
        src_a[k]  = a;
        src_bx[k] = bx;
        src_c[k]  = c0;
        src_v[k]  = in_valid;
      end else begin
        src_a[k]  = a_q[k-1];
        src_bx[k] = bx_q[k-1];
        src_s[k]  = s_q[k-1];
        src_c[k]  = c_q[k-1];
        src_v[k]  = v_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_seg
    adder_segment #(
      .SEG (SEG)
    ) u_seg (
      .a  (src_a[k][k*SEG +: SEG]),
      .b  (src_bx[k][k*SEG +: SEG]),
      .ci (src_c[k]),
      .s  (seg_s[k]),
      .co (seg_c[k])
    );
  end

  // Splice this stage's segment into the forwarded lower result; ovf only matters in the last stage.
  always_comb begin
    nxt_ovf = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      nxt_s[k]               = src_s[k];
      nxt_s[k][k*SEG +: SEG] = seg_s[k];
      nxt_ovf[k] = (src_a[k][MSB] == src_bx[k][MSB]) && (nxt_s[k][MSB] != src_a[k][MSB]);
    end
  end

  // Whole pipe advances together unless the output is stalled; bubbles keep old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k]  <= '0;
        bx_q[k] <= '0;
        s_q[k]  <= '0;
      end
    end else if (!stall) begin
      v_q <= src_v;
      for (int k = 0; k < int'(STAGES); k++) begin
        if (src_v[k]) begin
          a_q[k]   <= src_a[k];
          bx_q[k]  <= src_bx[k];
          s_q[k]   <= nxt_s[k];
          c_q[k]   <= seg_c[k];
          ovf_q[k] <= nxt_ovf[k];
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (16/4) plus an exhaustive 6-bit, 2-stage sweep.
module tb_pipelined_adder;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, sub, cout, ovf;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [5:0]  s_a, s_b, s_sum;
  logic        s_cin, s_sub, s_cout, s_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] bb_a   [8] = '{16'h0000, 16'h1111, 16'h2222, 16'h3333,
                               16'h4444, 16'h5555, 16'h6666, 16'h7777};
  logic [15:0] bb_exp [8] = '{16'h0101, 16'h1212, 16'h2323, 16'h3434,
                               16'h4545, 16'h5656, 16'h6767, 16'h7878};

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(6), .STAGES(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat; junk is driven after the accept edge to prove operands are sampled once.
  task automatic run_beat(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                          input logic ts, output logic early, output logic rv,
                          output logic [15:0] rs, output logic rc, output logic ro);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = ~tc; sub = ~ts;
    step();
    step();
    early = out_valid;
    step();
    rv = out_valid; rs = sum; rc = cout; ro = ovf;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
    #13;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum got %h want 0000", sum); end
    n_checks++; if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_cout_ovf got %b want 00", {cout, ovf}); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_small_out_valid got %b want 0", s_out_valid); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_add_carry();
    logic e, v, c, o; logic [15:0] s;
    run_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, e, v, s, c, o);
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL carry_early_valid got %b want 0", e); end
    n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL carry_valid got %b want 1", v); end
    n_checks++; if ({s, c, o} !== {16'h0000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL carry_result got sum=%h cout=%b ovf=%b want 0000/1/0", s, c, o); end
  endtask

  task automatic test_overflow();
    logic e, v, c, o; logic [15:0] s;
    run_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, e, v, s, c, o);
    n_checks++; if ({v, s, c, o} !== {1'b1, 16'h8000, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL ovf_pos got v=%b sum=%h cout=%b ovf=%b want 1/8000/0/1", v, s, c, o); end
    run_beat(16'h8000, 16'hFFFF, 1'b0, 1'b0, e, v, s, c, o);
    n_checks++; if ({v, s, c, o} !== {1'b1, 16'h7FFF, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL ovf_neg got v=%b sum=%h cout=%b ovf=%b want 1/7fff/1/1", v, s, c, o); end
    run_beat(16'h1234, 16'h4321, 1'b1, 1'b0, e, v, s, c, o);
    n_checks++; if ({v, s, c, o} !== {1'b1, 16'h5556, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL add_cin got v=%b sum=%h cout=%b ovf=%b want 1/5556/0/0", v, s, c, o); end
  endtask

  task automatic test_sub();
    logic e, v, c, o; logic [15:0] s;
    run_beat(16'h0005, 16'h0007, 1'b0, 1'b1, e, v, s, c, o);
    n_checks++; if ({v, s, c, o} !== {1'b1, 16'hFFFE, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sub_borrow got v=%b sum=%h cout=%b ovf=%b want 1/fffe/0/0", v, s, c, o); end
    run_beat(16'h0005, 16'h0007, 1'b1, 1'b1, e, v, s, c, o);
    n_checks++; if ({v, s, c, o} !== {1'b1, 16'hFFFD, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sub_bin got v=%b sum=%h cout=%b ovf=%b want 1/fffd/0/0", v, s, c, o); end
    run_beat(16'h0007, 16'h0005, 1'b0, 1'b1, e, v, s, c, o);
    n_checks++; if ({v, s, c, o} !== {1'b1, 16'h0002, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sub_noborrow got v=%b sum=%h cout=%b ovf=%b want 1/0002/1/0", v, s, c, o); end
    run_beat(16'h8000, 16'h0001, 1'b0, 1'b1, e, v, s, c, o);
    n_checks++; if ({v, s, c, o} !== {1'b1, 16'h7FFF, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL sub_ovf got v=%b sum=%h cout=%b ovf=%b want 1/7fff/1/1", v, s, c, o); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; b = 16'h0101; cin = 1'b0; sub = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      if (e <= 8) begin in_valid = 1'b1; a = bb_a[e-1]; end
      else in_valid = 1'b0;
      step();
      if (e >= 4) begin
        n_checks++;
        if (out_valid !== 1'b1 || sum !== bb_exp[e-4]) begin
          n_fail++; $display("FAIL b2b_edge%0d got v=%b sum=%h want 1/%h", e, out_valid, sum, bb_exp[e-4]);
        end
      end else begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_latency_edge%0d got v=%b want 0", e, out_valid); end
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    int sent, rcvd; logic [15:0] held;
    sent = 0; rcvd = 0; held = '0;
    b = 16'h0101; cin = 1'b0; sub = 1'b0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      in_valid  = (sent < 8);
      if (sent < 8) a = bb_a[sent];
      #1;
      if (c >= 5 && c <= 7) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_c%0d got %b want 0", c, in_ready); end
        if (c == 5) held = sum;
        else begin
          n_checks++;
          if (sum !== held || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold_c%0d got v=%b sum=%h want 1/%h", c, out_valid, sum, held);
          end
        end
      end
      if (out_valid && out_ready) begin
        if (rcvd < 8) begin
          n_checks++;
          if (sum !== bb_exp[rcvd]) begin n_fail++; $display("FAIL bp_order_%0d got %h want %h", rcvd, sum, bb_exp[rcvd]); end
        end
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (rcvd != 8 || sent != 8) begin n_fail++; $display("FAIL bp_count got rcvd=%0d sent=%0d want 8/8", rcvd, sent); end
  endtask

  task automatic test_reset_midflight();
    logic any_v;
    out_ready = 1'b1; b = 16'h0101; cin = 1'b0; sub = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; a = bb_a[c];
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || sum !== 16'h0101) begin
      n_fail++; $display("FAIL rst_pre got v=%b sum=%h want 1/0101", out_valid, sum);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0000) begin
      n_fail++; $display("FAIL rst_async got v=%b sum=%h want 0/0000", out_valid, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    any_v = 1'b0;
    for (int c = 0; c < 6; c++) begin step(); any_v |= out_valid; end
    n_checks++;
    if (any_v !== 1'b0) begin n_fail++; $display("FAIL rst_stale got v=%b want 0", any_v); end
    a = 16'h1234; b = 16'h1111; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    n_checks++;
    if (out_valid !== 1'b1 || sum !== 16'h2345) begin
      n_fail++; $display("FAIL rst_first_beat got v=%b sum=%h want 1/2345", out_valid, sum);
    end
    step();
  endtask

  task automatic test_exhaustive_small();
    logic [7:0] q[$];
    logic [7:0] exp_v;
    logic [13:0] v;
    int ta, tb, tc, sa, sb, r, u, got_n;
    logic ec, eo;
    got_n = 0;
    s_out_ready = 1'b1;
    for (int n = 0; n < 16384 + 6; n++) begin
      if (n < 16384) begin
        v = 14'(n);
        ta = int'(v[11:6]); tb = int'(v[5:0]); tc = int'(v[12]);
        sa = (ta >= 32) ? ta - 64 : ta;
        sb = (tb >= 32) ? tb - 64 : tb;
        if (v[13]) begin
          u = ta - tb - tc; r = sa - sb - tc; ec = (ta >= tb + tc);
        end else begin
          u = ta + tb + tc; r = sa + sb + tc; ec = (u >= 64);
        end
        eo = (r > 31) || (r < -32);
        exp_v = {ec, eo, 6'(u & 63)};
        q.push_back(exp_v);
        s_a = v[11:6]; s_b = v[5:0]; s_cin = v[12]; s_sub = v[13]; s_in_valid = 1'b1;
      end else begin
        s_in_valid = 1'b0;
      end
      step();
      if (s_out_valid) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL sweep_extra got sum=%h want no beat", s_sum);
        end else begin
          exp_v = q.pop_front();
          got_n++;
          if ({s_cout, s_ovf, s_sum} !== exp_v) begin
            n_fail++; $display("FAIL sweep_%0d got cout/ovf/sum=%b/%b/%h want %b/%b/%h",
                               got_n - 1, s_cout, s_ovf, s_sum, exp_v[7], exp_v[6], exp_v[5:0]);
          end
        end
      end
    end
    n_checks++;
    if (got_n != 16384 || q.size() != 0) begin
      n_fail++; $display("FAIL sweep_count got %0d left=%0d want 16384/0", got_n, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_overflow();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_exhaustive_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
